// File: rtl/fifo_3to8_if.sv
// Bus bundle for the 3-bit-in / 8-bit-out packing FIFO.
// The master side (producer/consumer) drives the requests and the FIFO (slave) returns data and status.
interface fifo_3to8_if #(
  parameter int DEPTH_BITS = 128
);
  localparam int CW = $clog2(DEPTH_BITS) + 1;

  logic          w_en;
  logic [2:0]    data_w;
  logic          r_en;
  logic [7:0]    data_r;
  logic          empty;
  logic          full;
  logic          half_full;
  logic          overflow;
  logic          underflow;
  logic [CW-1:0] count;

  modport master (
    output w_en, data_w, r_en,
    input  data_r, empty, full, half_full, overflow, underflow, count
  );

  modport slave (
    input  w_en, data_w, r_en,
    output data_r, empty, full, half_full, overflow, underflow, count
  );
endinterface

// File: rtl/fifo_3to8.sv
// Packing FIFO: 3-bit symbols in, LSB-first bytes out, over a circular bit buffer.
// data_r is first-word-fall-through; all status flags derive from the stored-bit count.
module fifo_3to8 #(
  parameter int DEPTH_BITS = 128,
  parameter int CW         = $clog2(DEPTH_BITS) + 1
) (
  input logic        clk,
  input logic        rst_n,
  fifo_3to8_if.slave bus
);
  localparam int PW = $clog2(DEPTH_BITS);

  logic [DEPTH_BITS-1:0] mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic                  empty_c;
  logic                  full_c;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [7:0]            head;

  // Handshake: w_en is a request that completes only when full=0 and r_en only
  // when empty=0 (both judged on the pre-edge count); a request against a blocked
  // side is dropped with no state change other than its sticky overflow/underflow bit.
  assign empty_c = count_q < CW'(8);
  assign full_c  = count_q > CW'(DEPTH_BITS - 3);
  assign wr_ok   = bus.w_en && !full_c;
  assign rd_ok   = bus.r_en && !empty_c;

  assign bus.empty     = empty_c;
  assign bus.full      = full_c;
  assign bus.half_full = (count_q >= CW'(DEPTH_BITS / 2)) && !full_c;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.count     = count_q;

  for (genvar i = 0; i < 8; i++) begin : g_head
    assign head[i] = mem[rd_ptr + PW'(i)];
  end

  // Storage is never reset, so mask the head byte to a known value while empty.
  assign bus.data_r = empty_c ? 8'h00 : head;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr]          <= bus.data_w[0];
      mem[wr_ptr + PW'(1)] <= bus.data_w[1];
      mem[wr_ptr + PW'(2)] <= bus.data_w[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(3);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(8);
      count_q <= count_q + (wr_ok ? CW'(3) : CW'(0)) - (rd_ok ? CW'(8) : CW'(0));

      // A new rejection wins over the clearing event on the same edge.
      if (bus.w_en && full_c) overflow_q <= 1'b1;
      else if (rd_ok)         overflow_q <= 1'b0;

      if (bus.r_en && empty_c) underflow_q <= 1'b1;
      else if (wr_ok)          underflow_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_3to8.sv
// Bench for fifo_3to8: directed plan steps plus random traffic, checked against a
// bit-queue reference model of the packing FIFO.
module tb_fifo_3to8;
  localparam int DEPTH = 128;

  logic clk;
  logic rst_n;

  fifo_3to8_if #(.DEPTH_BITS(DEPTH)) bus ();

  fifo_3to8 #(.DEPTH_BITS(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stored bits in arrival order plus the two sticky flags.
  logic exp_q[$];
  logic m_ov;
  logic m_un;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = exp_q[i];
    return b;
  endfunction

  function automatic logic [3:0] exp_flags();
    int  sz;
    logic e, f, h;
    sz = exp_q.size();
    e  = (sz < 8);
    f  = ((DEPTH - sz) < 3);
    h  = (2 * sz >= DEPTH) && !f;
    return {e, h, f, m_ov};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.empty, bus.half_full, bus.full, bus.overflow};
  endfunction

  task automatic check_all();
    chk("count", 32'(bus.count), 32'(exp_q.size()));
    chk("flags", 32'(dut_flags()), 32'(exp_flags()));
    chk("underflow", 32'(bus.underflow), 32'(m_un));
    if (exp_q.size() >= 8) chk("data_r", 32'(bus.data_r), 32'(exp_byte()));
  endtask

  // Driver: one clock cycle of requests, model update, then full check.
  task automatic step(input logic we, input logic [2:0] d, input logic re);
    int   sz;
    logic wa, ra;
    @(negedge clk);
    bus.w_en   = we;
    bus.data_w = d;
    bus.r_en   = re;
    sz = exp_q.size();
    wa = we && ((DEPTH - sz) >= 3);
    ra = re && (sz >= 8);
    @(posedge clk);
    #1;
    if (ra) repeat (8) void'(exp_q.pop_front());
    if (wa) for (int k = 0; k < 3; k++) exp_q.push_back(d[k]);
    if (we && !wa) m_ov = 1'b1;
    else if (ra)   m_ov = 1'b0;
    if (re && !ra) m_un = 1'b1;
    else if (wa)   m_un = 1'b0;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    check_all();
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #25;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_flags", 32'(dut_flags()), 32'(4'b1000));
    chk("rst_underflow", 32'(bus.underflow), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_data_r", 32'(bus.data_r), 32'h00);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    bus.w_en   = 1'b0;
    bus.r_en   = 1'b0;
    bus.data_w = 3'd0;
    clear_model();

    // 1. Reset
    do_reset();

    // 2. Pack three words into one byte
    step(1'b1, 3'b101, 1'b0);
    step(1'b1, 3'b110, 1'b0);
    chk("pack_empty_before", 32'(bus.empty), 32'd1);
    step(1'b1, 3'b011, 1'b0);
    chk("pack_count", 32'(bus.count), 32'd9);
    chk("pack_empty", 32'(bus.empty), 32'd0);
    chk("pack_byte", 32'(bus.data_r), 32'hF5);
    step(1'b0, 3'b000, 1'b1);
    chk("pack_pop_count", 32'(bus.count), 32'd1);
    chk("pack_pop_empty", 32'(bus.empty), 32'd1);

    // 3. Fill from empty
    do_reset();
    for (int i = 1; i <= 42; i++) begin
      step(1'b1, 3'b111, 1'b0);
      if (i == 21) chk("fill21_flags", 32'(dut_flags()), 32'(4'b0000));
      if (i == 22) chk("fill22_half", 32'(bus.half_full), 32'd1);
    end
    chk("fill42_flags", 32'(dut_flags()), 32'(4'b0010));
    chk("fill42_count", 32'(bus.count), 32'd126);
    chk("fill42_byte", 32'(bus.data_r), 32'hFF);

    // 4. Overflow and its clearing read
    step(1'b1, 3'b010, 1'b0);
    chk("ovf_count", 32'(bus.count), 32'd126);
    chk("ovf_flags", 32'(dut_flags()), 32'(4'b0011));
    step(1'b0, 3'b000, 1'b1);
    chk("ovf_read_count", 32'(bus.count), 32'd118);
    chk("ovf_read_flags", 32'(dut_flags()), 32'(4'b0100));

    // 5. Simultaneous read and write, then underflow
    do_reset();
    step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    step(1'b1, 3'b111, 1'b0);
    step(1'b1, 3'b010, 1'b1);
    chk("sim_count", 32'(bus.count), 32'd4);
    chk("sim_empty", 32'(bus.empty), 32'd1);
    step(1'b0, 3'b000, 1'b1);
    chk("unf_set", 32'(bus.underflow), 32'd1);
    chk("unf_count", 32'(bus.count), 32'd4);
    step(1'b1, 3'b110, 1'b0);
    chk("unf_clear", 32'(bus.underflow), 32'd0);
    chk("unf_write_count", 32'(bus.count), 32'd7);

    // 6. Streaming across many wraps, with an asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", 32'(dut_flags()), 32'(4'b1000));
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_underflow", 32'(bus.underflow), 32'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step(1'b1, 3'(i % 8), exp_q.size() >= 8);
    end

    // Random traffic: write-heavy to hit full/overflow, then read-heavy to hit underflow
    for (int c = 0; c < 600; c++) begin
      if (c < 300)
        step($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 2);
      else
        step($urandom_range(0, 9) < 3, 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_3to8.md
Name: fifo_3to8

Overview:
- Width-converting FIFO: accepts 3-bit words on the write side and delivers 8-bit words on the read side.
- It is the packer counterpart to the team's 8-bit-in / 3-bit-out FIFO. It collects a 3-bit symbol stream back into bytes.
- Storage is a circular bit buffer. The status flags (empty, half_full, full, overflow) have the same meanings as on the unpacker side.

Parameters:
- DEPTH_BITS, 128, storage capacity in bits. Must be a power of two and at least 16.
- CW, $clog2(DEPTH_BITS)+1, width of the fill counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- w_en  input  1  write request; pushes data_w this cycle.
- data_w  input  3  write word.
- r_en  input  1  read request; pops data_r this cycle.
- data_r  output  8  head byte, first-word-fall-through.
- empty  output  1  fewer than 8 bits stored; no byte readable.
- full  output  1  fewer than 3 bits free; no word writable.
- half_full  output  1  count >= DEPTH_BITS/2 and not full.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- count  output  CW  number of stored bits.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1; full=0, half_full=0, overflow=0, underflow=0.
  - data_r=8'h00.
  - Storage contents need not be cleared.
- Bit order is LSB-first.
  - An accepted write stores data_w[0..2] at bit positions wr_ptr, wr_ptr+1, wr_ptr+2 (mod DEPTH_BITS).
  - data_r[i] = mem[(rd_ptr+i) mod DEPTH_BITS] for i=0..7.
  - A 3-bit word may straddle two output bytes and the wrap point.
- Pointers are bit indices of width $clog2(DEPTH_BITS) and wrap naturally.
- Flags are combinational from count only:
  - empty = count<8.
  - full = count>DEPTH_BITS-3.
  - half_full = (count>=DEPTH_BITS/2) && !full.
- Write accepted = w_en && !full, using the pre-edge count. On acceptance: wr_ptr+=3, count+=3.
- Read accepted = r_en && !empty, using the pre-edge count.
  - On acceptance: rd_ptr+=8, count-=8.
  - data_r is valid whenever empty=0. It shows the next byte in the cycle after a pop, with zero read latency.
  - While empty=1, data_r contents are don't-care.
- Simultaneous accepted read and write: both take effect, count+=3-8.
  - A write accepted at count>=8 does not alter the bits being read.
  - A read is never permitted to consume bits written in the same edge.
- Rejected write (w_en && full): no state change except overflow<=1.
- Rejected read (r_en && empty): no state change except underflow<=1.
- Overflow is cleared on the next accepted read. Underflow is cleared on the next accepted write. Set takes priority if both occur on the same edge.
- Reset asserted mid-operation discards all buffered bits immediately; flags return to reset values asynchronously.
- Never-ready conditions do not exist at DEPTH_BITS>=16: from full a read is always possible; from empty a write is always possible.

Test Plan:
1. Reset: hold rst_n=0 for 25 ns, release -> {empty,half_full,full,overflow}=4'b1000, underflow=0, count=0.
2. Pack: write 3'b101, 3'b110, 3'b011 -> empty falls after the third write; count=9; data_r=8'hF5. Assert r_en for one cycle -> count=1, empty=1.
3. Fill from empty with 42 writes of 3'b111:
   - after 21 writes (63 bits): flags 4'b0000;
   - after 22 writes (66 bits): half_full=1;
   - after 42 writes (126 bits): flags 4'b0010, data_r=8'hFF.
4. Overflow:
   - 43rd write while full -> count stays 126, flags 4'b0011.
   - One read -> count=118, flags 4'b0100, overflow=0.
5. Simultaneous: at count=9, w_en=r_en=1 for one cycle -> count=4, empty=1. Next r_en -> underflow=1, count=4. Next write -> underflow=0, count=7.
6. Wrap and reset:
   - Stream 300 words of 3-bit incrementing pattern (i mod 8) while reading whenever !empty.
   - Every popped byte must equal the software-packed LSB-first stream across many pointer wraps.
   - Assert rst_n=0 mid-stream -> flags 4'b1000 and count=0 within the same cycle.
